// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_e;

  localparam int unsigned ITER_COUNT    = 32;
  localparam logic [31:0] QUOT_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  function automatic logic op_a_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_b_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_is_rem(input md_op_e op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage request/result bundle for the multiply/divide sequencer.
interface ex_muldiv_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] port_a_i;
  logic [XLEN-1:0] port_b_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, port_a_i, port_b_i, flush_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, port_a_i, port_b_i, flush_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv_ctrl_datapath.sv
// Shared shift-add / restoring shift-subtract datapath with sign fix-up and result register.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            special_i,
  input  logic [XLEN-1:0] special_res_i,
  input  logic            step_i,
  input  logic            fix_i,
  input  logic [4:0]      cnt_i,
  input  md_op_e          op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  md_op_e            op_q;
  logic [XLEN-1:0]   mag_a_q, mag_b_q, result_q;
  logic              neg_q;
  logic [2*XLEN-1:0] acc_q;

  logic              a_neg, b_neg, neg_d, ge;
  logic [XLEN-1:0]   mag_a_d, mag_b_d, rem_next, quo_fix, rem_fix, fix_res;
  logic [XLEN:0]     addend, sum, shifted, diff;
  logic [4:0]        bit_idx;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;

  always_comb begin
    a_neg   = op_a_signed(op_i) & a_i[XLEN-1];
    b_neg   = op_b_signed(op_i) & b_i[XLEN-1];
    mag_a_d = a_neg ? -a_i : a_i;
    mag_b_d = b_neg ? -b_i : b_i;
    neg_d   = op_is_rem(op_i) ? a_neg : (a_neg ^ b_neg);
  end

  // Multiply consumes |b| LSB-first; divide consumes |a| MSB-first into the remainder.
  always_comb begin
    addend   = mag_b_q[cnt_i] ? {1'b0, mag_a_q} : '0;
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + addend;
    mul_next = {sum, acc_q[XLEN-1:1]};

    bit_idx  = 5'(XLEN - 1) - cnt_i;
    shifted  = {acc_q[2*XLEN-1:XLEN], mag_a_q[bit_idx]};
    diff     = shifted - {1'b0, mag_b_q};
    ge       = ~diff[XLEN];
    rem_next = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    div_next = {rem_next, acc_q[XLEN-2:0], ge};
  end

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_res  = '0;
    unique case (op_q)
      MD_MUL:                       fix_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_res = quo_fix;
      MD_REM, MD_REMU:              fix_res = rem_fix;
      default:                      fix_res = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q     <= MD_MUL;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else if (load_i) begin
      op_q    <= op_i;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      acc_q   <= '0;
      if (special_i) result_q <= special_res_i;
    end else if (step_i) begin
      acc_q <= op_q[2] ? div_next : mul_next;
    end else if (fix_i) begin
      result_q <= fix_res;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle RISC-V M-extension sequencer: FSM, iteration counter and EX stall generation.
module ex_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FAST_SPECIAL = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ex_muldiv_ctrl_if.slave  ex
);

  md_state_e  state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  md_op_e          op;
  logic            accept, div_by_zero, div_ovf, special;
  logic            step, fix;
  logic [XLEN-1:0] special_res;

  always_comb begin
    op          = md_op_e'(ex.op_i);
    accept      = (state_q == ST_IDLE) & ex.start_i & ~ex.flush_i;
    div_by_zero = ex.op_i[2] & (ex.port_b_i == '0);
    div_ovf     = ((op == MD_DIV) || (op == MD_REM)) &
                  (ex.port_a_i == INT_MIN) & (ex.port_b_i == '1);
    special     = (FAST_SPECIAL != 0) & (div_by_zero | div_ovf);
    if (div_by_zero) special_res = ex.op_i[1] ? ex.port_a_i : QUOT_ALL_ONES;
    else             special_res = ex.op_i[1] ? '0 : INT_MIN;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    fix     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        cnt_d   = '0;
        state_d = special ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER_COUNT - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        fix     = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Flush overrides everything and leaves result_o untouched.
    if (ex.flush_i) begin
      state_d = ST_IDLE;
      step    = 1'b0;
      fix     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex.busy_o  = (state_q != ST_IDLE);
  assign ex.done_o  = (state_q == ST_DONE) & ~ex.flush_i;
  assign ex.stall_o = ~ex.flush_i & (((state_q == ST_IDLE) & ex.start_i) |
                                     (state_q == ST_CALC) | (state_q == ST_FIX));

  muldiv_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .load_i        (accept),
    .special_i     (special),
    .special_res_i (special_res),
    .step_i        (step),
    .fix_i         (fix),
    .cnt_i         (cnt_q),
    .op_i          (op),
    .a_i           (ex.port_a_i),
    .b_i           (ex.port_b_i),
    .result_o      (ex.result_o)
  );

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl with hand-computed results and latencies.
module tb_ex_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  ex_muldiv_ctrl_if #(.XLEN(32)) ex ();

  ex_muldiv_ctrl #(
    .XLEN         (32),
    .FAST_SPECIAL (1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .ex    (ex.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an op in the current cycle (T) and follows it to done_o and one cycle beyond.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit hold);
    int lat;
    int stalls;
    ex.start_i  = 1'b1;
    ex.op_i     = op;
    ex.port_a_i = a;
    ex.port_b_i = b;
    #1;
    lat    = 0;
    stalls = 0;
    while (!ex.done_o && lat < 100) begin
      if (ex.stall_o) stalls++;
      tick();
      lat++;
      if (!hold) ex.start_i = 1'b0;
      #1;
    end
    chk({tag, ".lat"},    32'(lat), 32'(exp_lat));
    chk({tag, ".stalls"}, 32'(stalls), 32'(exp_lat));
    chk({tag, ".res"},    ex.result_o, exp);
    chk({tag, ".stall_at_done"}, {31'b0, ex.stall_o}, 32'd0);
    last_res = exp;
    tick();
    ex.start_i = 1'b0;
    #1;
    chk({tag, ".done_after"}, {31'b0, ex.done_o}, 32'd0);
    chk({tag, ".busy_after"}, {31'b0, ex.busy_o}, 32'd0);
  endtask

  initial begin
    int dones;
    ex.start_i  = 1'b0;
    ex.op_i     = '0;
    ex.port_a_i = '0;
    ex.port_b_i = '0;
    ex.flush_i  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy",   {31'b0, ex.busy_o},  32'd0);
    chk("rst.done",   {31'b0, ex.done_o},  32'd0);
    chk("rst.stall",  {31'b0, ex.stall_o}, 32'd0);
    chk("rst.result", ex.result_o, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("mul",    MD_MUL,    32'd7,          32'd6,          32'd42,         34, 1'b0);
    run_op("mulh",   MD_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 34, 1'b0);
    run_op("mulhsu", MD_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 34, 1'b0);
    run_op("mulhu",  MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 34, 1'b0);
    run_op("div",    MD_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 34, 1'b0);
    run_op("rem",    MD_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 34, 1'b0);
    run_op("divu",   MD_DIVU,   32'd100,        32'd7,          32'd14,        34, 1'b0);
    run_op("remu",   MD_REMU,   32'd100,        32'd7,          32'd2,         34, 1'b0);
    run_op("divu0",  MD_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF, 1,  1'b0);
    run_op("rem0",   MD_REMU,   32'd5,          32'd0,          32'd5,         1,  1'b0);
    run_op("removf", MD_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         1,  1'b0);
    run_op("divovf", MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1,  1'b0);
    run_op("mulneg", MD_MUL,    32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1, 34, 1'b0);

    // Flush mid-multiply at T+10, new divide accepted at T+12.
    ex.start_i  = 1'b1;
    ex.op_i     = MD_MUL;
    ex.port_a_i = 32'd3;
    ex.port_b_i = 32'd4;
    tick();
    ex.start_i = 1'b0;
    repeat (9) tick();
    ex.flush_i = 1'b1;
    #1;
    chk("flush.stall_comb", {31'b0, ex.stall_o}, 32'd0);
    chk("flush.done_comb",  {31'b0, ex.done_o},  32'd0);
    tick();
    ex.flush_i = 1'b0;
    #1;
    chk("flush.busy",   {31'b0, ex.busy_o},  32'd0);
    chk("flush.stall",  {31'b0, ex.stall_o}, 32'd0);
    chk("flush.done",   {31'b0, ex.done_o},  32'd0);
    chk("flush.result", ex.result_o, last_res);
    tick();
    run_op("divu_after_flush", MD_DIVU, 32'd9, 32'd3, 32'd3, 34, 1'b0);

    // Start with flush in the same cycle is not accepted.
    ex.start_i = 1'b1;
    ex.flush_i = 1'b1;
    #1;
    chk("startflush.stall", {31'b0, ex.stall_o}, 32'd0);
    tick();
    ex.start_i = 1'b0;
    ex.flush_i = 1'b0;
    #1;
    chk("startflush.busy", {31'b0, ex.busy_o}, 32'd0);

    // start_i held through CALC and DONE yields exactly one completion.
    run_op("hold_mul", MD_MULHU, 32'h0001_0000, 32'h0003_0000, 32'd3, 34, 1'b1);
    run_op("hold_sp",  MD_DIV,   32'd1,         32'd0,         32'hFFFF_FFFF, 1, 1'b1);

    // Asynchronous reset in the middle of a divide.
    ex.start_i  = 1'b1;
    ex.op_i     = MD_DIV;
    ex.port_a_i = 32'd1000;
    ex.port_b_i = 32'd7;
    tick();
    ex.start_i = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.busy",   {31'b0, ex.busy_o},  32'd0);
    chk("midrst.stall",  {31'b0, ex.stall_o}, 32'd0);
    chk("midrst.result", ex.result_o, 32'd0);
    #2;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ex.done_o) dones++;
    end
    chk("midrst.no_done", 32'(dones), 32'd0);
    run_op("rem_after_rst", MD_REM, 32'd1000, 32'hFFFF_FFF9, 32'd6, 34, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
